// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the time-shared serial pattern detector:
//   - state_e       : scheduler FSM states (IDLE, SHIFT, DRAIN, REPORT)
//   - DEF_*         : default geometry and pattern (1101, first bit = MSB)
//   - id_width()    : requester-id width for a given requester count
//   - cnt_width()   : hit-counter width for a given frame length
//   - ID_W, CNT_W   : those widths evaluated for the default geometry
// ---------------------------------------------------------------------------
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int         DEF_N_REQ     = 4;
  localparam int         DEF_FRAME_LEN = 8;
  localparam int         DEF_PAT_W     = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1101;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int ID_W  = id_width(DEF_N_REQ);
  localparam int CNT_W = cnt_width(DEF_FRAME_LEN);

endpackage

// File: rtl/seq_pat_detector.sv
// ---------------------------------------------------------------------------
// seq_pat_detector
// Moore serial pattern detector. State is the length of the pattern prefix
// matched so far (0..PAT_W); overlapping matches are followed by falling back
// to the longest suffix that is still a pattern prefix.
// Ports:
//   clk   in  : rising-edge clock
//   rst_n in  : asynchronous active-low reset
//   clr   in  : synchronous clear of match progress (takes priority over din)
//   din   in  : serial bit, sampled every rising edge
//   hit   out : registered, high for the cycle after the completing bit
// ---------------------------------------------------------------------------
module seq_pat_detector
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic hit
);

  localparam int SW = $clog2(PAT_W + 1);

  logic [SW-1:0] state_q, state_d;
  logic          hit_q;

  // Longest k such that the last k bits of (matched prefix, b) equal the
  // first k pattern bits; pattern bit i (0 = first received) is PATTERN[PAT_W-1-i].
  function automatic logic [SW-1:0] next_state(input logic [SW-1:0] s, input logic b);
    logic [SW-1:0] res;
    logic          ok;
    logic          c;
    int            idx;
    res = {SW{1'b0}};
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= int'(s) + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          idx = int'(s) + 1 - k + j;
          if (idx == int'(s)) c = b;
          else                c = PATTERN[PAT_W-1-idx];
          if (c != PATTERN[PAT_W-1-j]) ok = 1'b0;
        end
        if (ok) res = SW'(k);
      end
    end
    return res;
  endfunction

  // Next match progress: clear wins, otherwise advance on din.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = {SW{1'b0}};
    end else begin
      state_d = next_state(state_q, din);
    end
  end

  // Progress register and registered Moore hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {SW{1'b0}};
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= (state_d == SW'(PAT_W));
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/seq_detect_sched.sv
// ---------------------------------------------------------------------------
// seq_detect_sched
// Round-robin scheduler sharing one seq_pat_detector among N_REQ requesters.
// A granted frame is shifted MSB-first into the detector, hits (overlapping
// included) are counted, and the result is reported with a one-cycle strobe.
// Optional feature macro: SEQ_DETECT_SCHED_FIRST_HIT_EN adds first_hit_pos.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req[N_REQ]            : level requests, sampled only in IDLE
//   frame_data            : frame i at [i*FRAME_LEN +: FRAME_LEN]
//   gnt[N_REQ]            : one-hot pulse in the first SHIFT cycle
//   busy                  : high in SHIFT/DRAIN/REPORT
//   det_bit, hit          : detector serial input / Moore output
//   done                  : one-cycle result strobe
//   done_id, match_cnt, match_any, first_hit_pos : results, held until next report
// ---------------------------------------------------------------------------
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int               N_REQ     = DEF_N_REQ,
  parameter int               FRAME_LEN = DEF_FRAME_LEN,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = DEF_PATTERN,
  localparam int              IDW       = id_width(N_REQ),
  localparam int              CW        = cnt_width(FRAME_LEN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_LEN-1:0] frame_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       det_bit,
  output logic                       hit,
  output logic                       done,
  output logic [IDW-1:0]             done_id,
  output logic [CW-1:0]              match_cnt,
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
  output logic [CW-1:0]              first_hit_pos,
`endif
  output logic                       match_any
);

  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

  state_e               state_q;
  logic [IDW-1:0]       ptr_q;
  logic [FRAME_LEN-1:0] shreg_q;
  logic [CW-1:0]        bitcnt_q;
  logic [CW-1:0]        cnt_q;
  logic [N_REQ-1:0]     gnt_q;
  logic                 busy_q, det_bit_q, done_q, match_any_q;
  logic [IDW-1:0]       done_id_q;
  logic [CW-1:0]        match_cnt_q;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
  logic [CW-1:0]        first_q, first_pos_q;
`endif

  logic                 win_valid_s, take_s, grant_s, hit_s, cnt_inc_s;
  logic [IDW-1:0]       win_id_s;
  logic [FRAME_LEN-1:0] win_frame_s;

  // Round-robin pick: first set request searching upward from ptr+1 with wrap.
  always_comb begin
    int idx;
    win_valid_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    take_s      = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx         = (int'(ptr_q) + i) % N_REQ;
      take_s      = !win_valid_s && req[idx];
      win_id_s    = take_s ? IDW'(idx) : win_id_s;
      win_valid_s = win_valid_s | req[idx];
    end
  end

  assign grant_s     = (state_q == IDLE) && win_valid_s;
  assign win_frame_s = frame_data[int'(win_id_s)*FRAME_LEN +: FRAME_LEN];
  // A hit seen in SHIFT cycle 0 cannot belong to this frame (detector just cleared).
  assign cnt_inc_s   = hit_s && (((state_q == SHIFT) && (bitcnt_q != {CW{1'b0}})) ||
                                 (state_q == DRAIN));

  seq_pat_detector #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_s),
    .din   (det_bit_q),
    .hit   (hit_s)
  );

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_REQ - 1);
      shreg_q     <= {FRAME_LEN{1'b0}};
      bitcnt_q    <= {CW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      gnt_q       <= {N_REQ{1'b0}};
      busy_q      <= 1'b0;
      det_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= {IDW{1'b0}};
      match_cnt_q <= {CW{1'b0}};
      match_any_q <= 1'b0;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
      first_q     <= {CW{1'b0}};
      first_pos_q <= {CW{1'b0}};
`endif
    end else begin
      gnt_q  <= {N_REQ{1'b0}};
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            state_q   <= SHIFT;
            ptr_q     <= win_id_s;
            gnt_q     <= GNT_ONE << win_id_s;
            det_bit_q <= win_frame_s[FRAME_LEN-1];
            shreg_q   <= win_frame_s << 1;
            bitcnt_q  <= {CW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b1;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
            first_q   <= {CW{1'b0}};
`endif
          end
        end
        SHIFT: begin
          if (cnt_inc_s) cnt_q <= cnt_q + CNT_ONE;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
          // Hit in SHIFT cycle k was completed by bit k-1, i.e. 1-based index k.
          if (cnt_inc_s && (first_q == {CW{1'b0}})) first_q <= bitcnt_q;
`endif
          if (bitcnt_q == CW'(FRAME_LEN - 1)) begin
            state_q   <= DRAIN;
            det_bit_q <= 1'b0;
          end else begin
            det_bit_q <= shreg_q[FRAME_LEN-1];
            shreg_q   <= {shreg_q[FRAME_LEN-2:0], 1'b0};
            bitcnt_q  <= bitcnt_q + CNT_ONE;
          end
        end
        DRAIN: begin
          state_q     <= REPORT;
          done_q      <= 1'b1;
          done_id_q   <= ptr_q;
          match_cnt_q <= cnt_q + CW'(cnt_inc_s);
          match_any_q <= (cnt_q != {CW{1'b0}}) || cnt_inc_s;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
          first_pos_q <= ((first_q == {CW{1'b0}}) && cnt_inc_s) ? CW'(FRAME_LEN) : first_q;
`endif
        end
        REPORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign det_bit   = det_bit_q;
  assign hit       = hit_s;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign match_any = match_any_q;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
  assign first_hit_pos = first_pos_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
module tb_seq_detect_sched;
  import seq_detect_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req;
  logic [31:0]       frame_data;
  logic [3:0]        gnt;
  logic              busy, det_bit, hit, done, match_any;
  logic [ID_W-1:0]   done_id;
  logic [CNT_W-1:0]  match_cnt;
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
  logic [CNT_W-1:0]  first_hit_pos;
`endif

  int errors = 0;
  int checks = 0;

  seq_detect_sched #(
    .N_REQ(4), .FRAME_LEN(8), .PAT_W(4), .PATTERN(4'b1101)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_data(frame_data),
    .gnt(gnt), .busy(busy), .det_bit(det_bit), .hit(hit), .done(done),
    .done_id(done_id), .match_cnt(match_cnt),
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    .first_hit_pos(first_hit_pos),
`endif
    .match_any(match_any)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serve one frame: returns grant seen (0 on timeout), number of cycles gnt
  // was high, det_bit sequence of the 8 SHIFT cycles, and gnt-to-done latency
  // (-1 on timeout). Performs no comparisons.
  task automatic run_frame(input logic [3:0] r, input int id, input logic [7:0] f,
                           output logic [3:0] g, output int gcyc,
                           output logic [7:0] bits, output int lat);
    int c;
    g = 4'b0000; gcyc = 0; bits = 8'h00; lat = -1;
    frame_data[id*8 +: 8] = f;
    req = r;
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) break;
    end
    if (gnt == 4'b0000) begin
      req = 4'b0000;
      return;
    end
    g = gnt; gcyc = 1;
    req = 4'b0000;
    bits[7] = det_bit;
    for (c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) gcyc++;
      if (c < 8) bits[7-c] = det_bit;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; frame_data = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if ({busy, det_bit, hit, done, match_any} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, det_bit, hit, done, match_any}); end
    checks++; if ({done_id, match_cnt} !== 6'd0) begin errors++; $display("FAIL reset_results: got id=%0d cnt=%0d expected 0 0", done_id, match_cnt); end
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    checks++; if (first_hit_pos !== 4'd0) begin errors++; $display("FAIL reset_first: got %0d expected 0", first_hit_pos); end
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, gnt} !== 5'b00000) begin errors++; $display("FAIL idle_quiet: got busy=%b gnt=%b expected 0 0000", busy, gnt); end
  endtask

  task automatic test_basic();
    logic [3:0] g; int gc; logic [7:0] b; int lat;
    run_frame(4'b0010, 1, 8'b11011010, g, gc, b, lat);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL basic_gnt: got %b expected 0010", g); end
    checks++; if (gc !== 1) begin errors++; $display("FAIL basic_gnt_len: got %0d expected 1", gc); end
    checks++; if (b !== 8'b11011010) begin errors++; $display("FAIL basic_det_bits: got %b expected 11011010", b); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++; if (done_id !== 2'd1) begin errors++; $display("FAIL basic_id: got %0d expected 1", done_id); end
    checks++; if (match_cnt !== 4'd2) begin errors++; $display("FAIL basic_cnt: got %0d expected 2", match_cnt); end
    checks++; if (match_any !== 1'b1) begin errors++; $display("FAIL basic_any: got %b expected 1", match_any); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_report: got %b expected 1", busy); end
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    checks++; if (first_hit_pos !== 4'd4) begin errors++; $display("FAIL basic_first: got %0d expected 4", first_hit_pos); end
`endif
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    checks++; if (match_cnt !== 4'd2) begin errors++; $display("FAIL basic_cnt_hold: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_zero();
    logic [3:0] g; int gc; logic [7:0] b; int lat;
    run_frame(4'b0001, 0, 8'b00000000, g, gc, b, lat);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL zero_gnt: got %b expected 0001", g); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL zero_latency: got %0d expected 9", lat); end
    checks++; if ({done_id, match_cnt, match_any} !== 7'd0) begin errors++; $display("FAIL zero_result: got id=%0d cnt=%0d any=%b expected 0 0 0", done_id, match_cnt, match_any); end
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    checks++; if (first_hit_pos !== 4'd0) begin errors++; $display("FAIL zero_first: got %0d expected 0", first_hit_pos); end
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int c;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pulse_reset();
    frame_data = 32'h0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (gnt != 4'b0000) break;
      end
      checks++; if (gnt !== exp_g[n]) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b", n, gnt, exp_g[n]); end
      if (n > 0) begin
        checks++; if (c !== 11) begin errors++; $display("FAIL rr_spacing_%0d: got %0d expected 11", n, c); end
      end
    end
    req = 4'b0000;
    for (c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++; if (c !== 9) begin errors++; $display("FAIL rr_last_done: got %0d expected 9", c); end
  endtask

  task automatic test_cross_frame();
    logic [3:0] g; int gc; logic [7:0] b; int lat;
    run_frame(4'b0001, 0, 8'b00000110, g, gc, b, lat);
    checks++; if ({g, match_cnt} !== {4'b0001, 4'd0}) begin errors++; $display("FAIL cross_first: got gnt=%b cnt=%0d expected 0001 0", g, match_cnt); end
    run_frame(4'b0010, 1, 8'b10000000, g, gc, b, lat);
    checks++; if ({g, match_cnt, match_any} !== {4'b0010, 4'd0, 1'b0}) begin errors++; $display("FAIL cross_second: got gnt=%b cnt=%0d any=%b expected 0010 0 0", g, match_cnt, match_any); end
  endtask

  task automatic test_overlap();
    logic [3:0] g; int gc; logic [7:0] b; int lat;
    run_frame(4'b0100, 2, 8'b11011011, g, gc, b, lat);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL ovl_gnt: got %b expected 0100", g); end
    checks++; if (match_cnt !== 4'd2) begin errors++; $display("FAIL ovl_cnt: got %0d expected 2", match_cnt); end
    checks++; if (done_id !== 2'd2) begin errors++; $display("FAIL ovl_id: got %0d expected 2", done_id); end
`ifdef SEQ_DETECT_SCHED_FIRST_HIT_EN
    checks++; if (first_hit_pos !== 4'd4) begin errors++; $display("FAIL ovl_first: got %0d expected 4", first_hit_pos); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] g; int gc; logic [7:0] b; int lat; int c; int dones;
    frame_data[0 +: 8] = 8'b11011011;
    req = 4'b0001;
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) break;
    end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    repeat (4) @(negedge clk);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_hit_before: got %b expected 1", hit); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({gnt, busy, det_bit, hit, done, match_any} !== 9'd0) begin errors++; $display("FAIL mid_async_flags: got %b expected 000000000", {gnt, busy, det_bit, hit, done, match_any}); end
    checks++; if ({done_id, match_cnt} !== 6'd0) begin errors++; $display("FAIL mid_async_results: got id=%0d cnt=%0d expected 0 0", done_id, match_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", dones); end
    frame_data[16 +: 8] = 8'b00000000;
    run_frame(4'b0101, 0, 8'b00000000, g, gc, b, lat);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL mid_ptr_restart: got %b expected 0001", g); end
    run_frame(4'b0100, 2, 8'b00001101, g, gc, b, lat);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL mid_req2_gnt: got %b expected 0100", g); end
    checks++; if ({match_cnt, lat} !== {4'd1, 32'sd9}) begin errors++; $display("FAIL mid_req2_result: got cnt=%0d lat=%0d expected 1 9", match_cnt, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_round_robin();
    test_cross_frame();
    test_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
